// File: rtl/key_mode_ctrl.sv
// key_mode_ctrl: synchronises and debounces a raw push-button, turns each
// accepted press into a one-cycle pulse, and advances a display mode index
// that is only applied to the monitor at a frame boundary (vsync edge).
module key_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES  = 1000000,
    parameter int MODE_NUM         = 8,
    parameter int MODE_W           = 3,
    parameter bit KEY_ACTIVE_LOW   = 1'b1,
    parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_in,
    input  logic              vsync,
    output logic              key_pulse,
    output logic              key_level,
    output logic [MODE_W-1:0] mode,
    output logic              mode_pending,
    output logic              mode_changed
);

    localparam int                CNT_W        = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic              KEY_RELEASED = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [MODE_W-1:0] MODE_LAST    = MODE_W'(MODE_NUM - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    logic             key_meta;
    logic             key_sync;
    logic             key_s;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             level_next;
    logic             pulse_next;

    logic              vsync_act;
    logic              vsync_act_d;
    logic              frame_edge;
    logic [MODE_W-1:0] next_mode;
    logic [MODE_W-1:0] mode_inc;
    logic [MODE_W-1:0] next_mode_new;
    logic              pending_new;

    // Two-flop synchroniser on the raw button, then a third flop that
    // normalises polarity so key_s is always 1 while the button is pressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_meta <= KEY_RELEASED;
            key_sync <= KEY_RELEASED;
            key_s    <= 1'b0;
        end else begin
            key_meta <= key_in;
            key_sync <= key_meta;
            key_s    <= KEY_ACTIVE_LOW ? ~key_sync : key_sync;
        end
    end

    // Debounce state register, stable-level counter and registered key outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            key_level <= 1'b0;
            key_pulse <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            key_level <= level_next;
            key_pulse <= pulse_next;
        end
    end

    // Debounce next-state logic: a level change is accepted only after it has
    // been seen stable for the full window; any bounce restarts the wait.
    always_comb begin
        state_next = state;
        count_next = count;
        level_next = key_level;
        pulse_next = 1'b0;
        case (state)
            IDLE: begin
                level_next = 1'b0;
                if (key_s) begin
                    state_next = PRESS_WAIT;
                    count_next = '0;
                end
            end
            PRESS_WAIT: begin
                if (!key_s) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (count == CNT_LAST) begin
                    state_next = HELD;
                    count_next = '0;
                    level_next = 1'b1;
                    pulse_next = 1'b1;
                end else begin
                    count_next = count + CNT_W'(1);
                end
            end
            HELD: begin
                if (!key_s) begin
                    state_next = RELEASE_WAIT;
                    count_next = '0;
                end
            end
            RELEASE_WAIT: begin
                if (key_s) begin
                    state_next = HELD;
                    count_next = '0;
                end else if (count == CNT_LAST) begin
                    state_next = IDLE;
                    count_next = '0;
                    level_next = 1'b0;
                end else begin
                    count_next = count + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    // Frame boundary detection: vsync normalised to active-high and compared
    // with its value one cycle earlier to find the start of the sync pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_act_d <= 1'b0;
        end else begin
            vsync_act_d <= vsync_act;
        end
    end

    // Mode bookkeeping: a press arriving in the same cycle as the frame edge
    // is folded in before the commit, so no press is ever left behind.
    always_comb begin
        vsync_act     = VSYNC_ACTIVE_LOW ? ~vsync : vsync;
        frame_edge    = vsync_act & ~vsync_act_d;
        mode_inc      = (next_mode == MODE_LAST) ? '0 : next_mode + MODE_W'(1);
        next_mode_new = key_pulse ? mode_inc : next_mode;
        pending_new   = mode_pending | key_pulse;
    end

    // Pending mode accumulates presses; it is copied to the visible mode only
    // on a frame edge so the pattern never changes mid-frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            next_mode    <= '0;
            mode         <= '0;
            mode_pending <= 1'b0;
            mode_changed <= 1'b0;
        end else begin
            next_mode    <= next_mode_new;
            mode_changed <= 1'b0;
            if (frame_edge && pending_new) begin
                mode         <= next_mode_new;
                mode_pending <= 1'b0;
                mode_changed <= (next_mode_new != mode);
            end else begin
                mode_pending <= pending_new;
            end
        end
    end

endmodule

// File: doc/key_mode_ctrl.md
Name: key_mode_ctrl

Overview:
- Upstream stage of VGA_Monitor; drives its key_in-derived mode selection.
- Synchronises and debounces a raw push-button and emits a one-cycle press pulse.
- Advances a display-pattern mode index on each press.
- Applies a new mode only at a frame boundary (vsync assertion) so the monitor never switches pattern mid-frame.

Parameters:
- DEBOUNCE_CYCLES, 1000000, stable-level cycles required to accept a key transition (20 ms at 50 MHz).
- MODE_NUM, 8, number of display modes; mode wraps MODE_NUM-1 -> 0.
- MODE_W, 3, width of the mode outputs; must satisfy 2^MODE_W >= MODE_NUM.
- KEY_ACTIVE_LOW, 1, 1 = key_in low means pressed.
- VSYNC_ACTIVE_LOW, 1, 1 = vsync low is the sync pulse.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous, active-high reset
- key_in  in  1  raw asynchronous button
- vsync  in  1  frame sync from the VGA timing, same clk domain
- key_pulse  out  1  one-cycle pulse per debounced press
- key_level  out  1  debounced key state, 1 = pressed
- mode  out  MODE_W  committed display mode, consumed by the pattern generator
- mode_pending  out  1  a press has been accepted but not yet committed
- mode_changed  out  1  one-cycle pulse in the cycle mode takes a new value

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset values:
  - key_pulse=0, key_level=0, mode=0, mode_pending=0, mode_changed=0.
  - Synchroniser flops load the released level.
  - FSM=IDLE, counter=0, next_mode=0.
  - vsync delay flop loads the inactive level.
- Synchroniser: 2-flop on key_in, followed by polarity normalisation to pressed=1 (key_s).
- FSM states:
  - IDLE: key_level=0. key_s=1 -> PRESS_WAIT, counter cleared.
  - PRESS_WAIT: counter increments while key_s=1. key_s=0 -> IDLE, counter cleared (bounce rejected, no pulse). Counter == DEBOUNCE_CYCLES-1 with key_s=1 -> HELD; key_level<=1; key_pulse<=1 for exactly one cycle.
  - HELD: key_s=0 -> RELEASE_WAIT, counter cleared.
  - RELEASE_WAIT: counter increments while key_s=0. key_s=1 -> HELD (bounce rejected). Counter == DEBOUNCE_CYCLES-1 -> IDLE; key_level<=0. No pulse on release.
- Latency: key_in held pressed from edge 0 -> key_pulse high in the cycle after edge 3+DEBOUNCE_CYCLES. A steady hold produces exactly one pulse.
- Mode path:
  - Each accepted press sets next_mode <= (next_mode==MODE_NUM-1) ? 0 : next_mode+1 and sets mode_pending.
  - Multiple presses within one frame accumulate (2 presses = +2 modulo MODE_NUM).
- Frame boundary: vsync transitioning from inactive to active level, detected against a 1-cycle delayed copy. On that edge:
  - if mode_pending: mode <= next_mode; mode_pending <= 0; mode_changed <= 1 for one cycle when the new value differs from mode.
  - if not pending: nothing changes.
- Simultaneous press pulse and frame edge in the same cycle: that press is included in the commit. mode takes the incremented value, and mode_pending ends at 0.
- Wrap-around with a net change of 0 (presses totalling MODE_NUM in one frame): commit occurs, mode_pending clears, mode_changed stays 0.
- Reset mid-debounce or mid-frame: all state returns to reset values in the next cycle; pending presses are discarded. Key held through reset release must debounce afresh (one pulse after the full latency).
- Counter width: clog2(DEBOUNCE_CYCLES)+1 bits. The counter never exceeds DEBOUNCE_CYCLES-1.

Test Plan (sim with DEBOUNCE_CYCLES=16, MODE_NUM=4, active-low key and vsync):
- Clean press held 100 cycles, no vsync -> one key_pulse at cycle 19 after press; key_level=1; mode_pending=1; mode=0.
- Bounce: key_in low 10 cycles, high 3, low 30 -> no pulse during the first burst; exactly one pulse 19 cycles after the final low edge.
- Commit: one press, then vsync falls -> mode 0->1 and mode_changed high one cycle after the vsync fall; mode_pending=0. A second vsync fall with no press -> mode stays 1, no mode_changed.
- Accumulate/wrap: starting from mode=3, two presses inside one frame, then vsync falls -> mode=1. Four presses in one frame -> mode unchanged, mode_pending cleared, mode_changed=0.
- Simultaneous: force key_pulse and the vsync fall into the same cycle from mode=2 -> mode=3 committed that frame; mode_pending=0 afterwards.
- Reset: assert rst during PRESS_WAIT with one press pending -> next cycle all outputs 0 and mode=0. Key held through reset release -> single pulse 19 cycles after rst deasserts.
